// File: rtl/posit_pd_fifo_pkg.sv
// Shared decoded-posit definitions: bundle format, field widths and flag bit positions.
package posit_defines;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    AADD   = 2'd1,
    AMULT  = 2'd2
  } pd_type;

  localparam int PD_FLAG_W = 6;

  // Flag vector is {NaR, sign, zero, guard, round, sticky}, MSB first.
  localparam int PD_NAR    = 5;
  localparam int PD_SIGN   = 4;
  localparam int PD_ZERO   = 3;
  localparam int PD_GUARD  = 2;
  localparam int PD_ROUND  = 1;
  localparam int PD_STICKY = 0;

  // Arithmetic formats carry one extra scale bit of headroom for carry/product growth.
  function automatic int pd_scale_width(input int n, input int es, input pd_type pdt);
    int sw;
    sw = $clog2(n) + es + 1;
    if (pdt != NORMAL) sw = sw + 1;
    return sw;
  endfunction

  function automatic int pd_fraction_width(input int n, input int es, input pd_type pdt);
    int fw;
    case (pdt)
      AADD:    fw = (n - es - 2) + 3;
      AMULT:   fw = 2 * (n - es - 2);
      default: fw = n - es - 3;
    endcase
    return fw;
  endfunction

endpackage

// File: rtl/posit_pd_fifo_canon.sv
// Single-lane canonicaliser for decoded posit values; only built when POSIT_PD_CANON_EN
// is defined, otherwise this file contributes no module.
`ifdef POSIT_PD_CANON_EN
module posit_pd_canon
  import posit_defines::*;
#(
  parameter int SW = 6,
  parameter int FW = 12
) (
  input  logic [SW-1:0]        in_scale,
  input  logic [FW-1:0]        in_fraction,
  input  logic [PD_FLAG_W-1:0] in_flags,
  output logic [SW-1:0]        out_scale,
  output logic [FW-1:0]        out_fraction,
  output logic [PD_FLAG_W-1:0] out_flags
);

  // NaR takes precedence when a decoder raises both NaR and zero.
  always_comb begin
    out_scale    = in_scale;
    out_fraction = in_fraction;
    out_flags    = in_flags;
    if (in_flags[PD_NAR]) begin
      out_scale          = '0;
      out_fraction       = '0;
      out_flags          = '0;
      out_flags[PD_NAR]  = 1'b1;
      out_flags[PD_SIGN] = 1'b1;
    end else if (in_flags[PD_ZERO]) begin
      out_scale          = '0;
      out_fraction       = '0;
      out_flags          = '0;
      out_flags[PD_ZERO] = 1'b1;
    end
  end

endmodule
`endif

// File: rtl/posit_pd_fifo.sv
// Multi-lane elastic FIFO for decoded posit operands, first-word fall-through.
// Define POSIT_PD_CANON_EN to canonicalise zero/NaR lanes on push.
module posit_pd_fifo
  import posit_defines::*;
#(
  parameter int     POSIT_WIDTH = 16,
  parameter int     POSIT_ES    = 1,
  parameter pd_type PD_TYPE     = NORMAL,
  parameter int     LANES       = 4,
  parameter int     DEPTH       = 4,
  localparam int    SW          = pd_scale_width(POSIT_WIDTH, POSIT_ES, PD_TYPE),
  localparam int    FW          = pd_fraction_width(POSIT_WIDTH, POSIT_ES, PD_TYPE),
  localparam int    FL          = PD_FLAG_W,
  localparam int    CW          = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [LANES*SW-1:0] s_scale,
  input  logic [LANES*FW-1:0] s_fraction,
  input  logic [LANES*FL-1:0] s_flags,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [LANES*SW-1:0] m_scale,
  output logic [LANES*FW-1:0] m_fraction,
  output logic [LANES*FL-1:0] m_flags,
  output logic [CW-1:0]       count,
  output logic [LANES-1:0]    nar_seen
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [LANES*FL-1:0] flags;
    logic [LANES*FW-1:0] fraction;
    logic [LANES*SW-1:0] scale;
  } entry_t;

  entry_t              mem_q [DEPTH];
  entry_t              head;
  logic [LANES*SW-1:0] wr_scale;
  logic [LANES*FW-1:0] wr_fraction;
  logic [LANES*FL-1:0] wr_flags;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             s_ready_q, s_ready_d;
  logic [LANES-1:0] nar_seen_q, nar_seen_d;
  logic             empty, push, pop;

`ifdef POSIT_PD_CANON_EN
  for (genvar i = 0; i < LANES; i++) begin : g_canon
    posit_pd_canon #(
      .SW(SW),
      .FW(FW)
    ) u_canon (
      .in_scale    (s_scale[i*SW +: SW]),
      .in_fraction (s_fraction[i*FW +: FW]),
      .in_flags    (s_flags[i*FL +: FL]),
      .out_scale   (wr_scale[i*SW +: SW]),
      .out_fraction(wr_fraction[i*FW +: FW]),
      .out_flags   (wr_flags[i*FL +: FL])
    );
  end
`else
  assign wr_scale    = s_scale;
  assign wr_fraction = s_fraction;
  assign wr_flags    = s_flags;
`endif

  // Pointers carry a wrap bit, so equal pointers unambiguously mean empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = s_valid && s_ready_q;
  assign pop   = !empty && m_ready;

  // Storage is deliberately not reset; the reset pointers keep m_valid clean.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= '{flags: wr_flags, fraction: wr_fraction, scale: wr_scale};
  end

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    nar_seen_d = nar_seen_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      for (int i = 0; i < LANES; i++) begin
        nar_seen_d[i] = nar_seen_q[i] | head.flags[i*FL + PD_NAR];
      end
    end
    count_d   = count_q + CW'(push) - CW'(pop);
    s_ready_d = (count_d < CW'(DEPTH));
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      nar_seen_d = '0;
      s_ready_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      s_ready_q  <= 1'b0;
      nar_seen_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      s_ready_q  <= s_ready_d;
      nar_seen_q <= nar_seen_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign m_valid    = !empty;
  assign m_scale    = head.scale;
  assign m_fraction = head.fraction;
  assign m_flags    = head.flags;
  assign count      = count_q;
  assign nar_seen   = nar_seen_q;

endmodule

// File: tb/tb_posit_pd_fifo.sv
// Directed scoreboard bench for posit_pd_fifo; expected canonicalisation follows
// POSIT_PD_CANON_EN when the macro is defined for the build.
module tb_posit_pd_fifo;
  import posit_defines::*;

  localparam int LANES = 4;
  localparam int DEPTH = 4;
  localparam int SW    = pd_scale_width(16, 1, NORMAL);
  localparam int FW    = pd_fraction_width(16, 1, NORMAL);
  localparam int FL    = PD_FLAG_W;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int SCW   = LANES * SW;
  localparam int FRW   = LANES * FW;
  localparam int FLW   = LANES * FL;

  typedef struct packed {
    logic [SCW-1:0] scale;
    logic [FRW-1:0] fraction;
    logic [FLW-1:0] flags;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             s_valid = 1'b0;
  logic             m_ready = 1'b0;
  logic             s_ready, m_valid;
  logic [SCW-1:0]   m_scale;
  logic [FRW-1:0]   m_fraction;
  logic [FLW-1:0]   m_flags;
  logic [CW-1:0]    count;
  logic [LANES-1:0] nar_seen;
  ent_t             din;

  int               errors = 0;
  int               checks = 0;
  ent_t             sb_q[$];
  logic [LANES-1:0] nar_model = '0;

  always #5 clk = ~clk;

  posit_pd_fifo #(
    .POSIT_WIDTH(16),
    .POSIT_ES   (1),
    .PD_TYPE    (NORMAL),
    .LANES      (LANES),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_scale   (din.scale),
    .s_fraction(din.fraction),
    .s_flags   (din.flags),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_scale   (m_scale),
    .m_fraction(m_fraction),
    .m_flags   (m_flags),
    .count     (count),
    .nar_seen  (nar_seen)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t canon(input ent_t e);
    ent_t r = e;
`ifdef POSIT_PD_CANON_EN
    for (int i = 0; i < LANES; i++) begin
      if (e.flags[i*FL + PD_NAR]) begin
        r.scale[i*SW +: SW]    = '0;
        r.fraction[i*FW +: FW] = '0;
        r.flags[i*FL +: FL]    = 6'b110000;
      end else if (e.flags[i*FL + PD_ZERO]) begin
        r.scale[i*SW +: SW]    = '0;
        r.fraction[i*FW +: FW] = '0;
        r.flags[i*FL +: FL]    = 6'b001000;
      end
    end
`endif
    return r;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e.scale    = SCW'($urandom());
    e.fraction = FRW'({$urandom(), $urandom()});
    e.flags    = FLW'($urandom());
    return e;
  endfunction

  // Called at a falling edge with inputs settled; accounts for the handshakes of the
  // coming rising edge, then advances to the next falling edge.
  task automatic tick();
    ent_t e;
    check("m_valid_vs_model", 64'(m_valid), 64'(sb_q.size() != 0));
    check("count_vs_model", 64'(count), 64'(sb_q.size()));
    if (m_valid && m_ready) begin
      check("pop_has_expected", 64'(sb_q.size() != 0), 64'(1'b1));
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("pop_scale", 64'(m_scale), 64'(e.scale));
        check("pop_fraction", 64'(m_fraction), 64'(e.fraction));
        check("pop_flags", 64'(m_flags), 64'(e.flags));
        for (int i = 0; i < LANES; i++) begin
          if (e.flags[i*FL + PD_NAR]) nar_model[i] = 1'b1;
        end
      end
    end
    if (flush) begin
      sb_q.delete();
      nar_model = '0;
    end else if (s_valid && s_ready) begin
      sb_q.push_back(canon(din));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    din = '0;

    // reset state while rst_n is held low
    #12;
    check("rst_m_valid", 64'(m_valid), 64'(1'b0));
    check("rst_s_ready", 64'(s_ready), 64'(1'b0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_nar_seen", 64'(nar_seen), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("s_ready_before_first_edge", 64'(s_ready), 64'(1'b0));
    @(posedge clk);
    #1 check("s_ready_after_first_edge", 64'(s_ready), 64'(1'b1));
    @(negedge clk);

    // single push: lane0 scale -3, fraction 0x2A5, flags 0
    din = '0;
    din.scale[SW-1:0]    = SW'(-3);
    din.fraction[FW-1:0] = FW'(12'h2A5);
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    check("single_m_valid", 64'(m_valid), 64'(1'b1));
    check("single_scale_lane0", 64'(m_scale[SW-1:0]), 64'(6'h3D));
    check("single_fraction_lane0", 64'(m_fraction[FW-1:0]), 64'(12'h2A5));
    check("single_count", 64'(count), 64'(1));
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("single_count_after_pop", 64'(count), 64'(0));
    check("single_m_valid_after_pop", 64'(m_valid), 64'(1'b0));

    // fill with sink stalled: six offers, four accepted
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din = rnd_ent();
      check("fill_s_ready", 64'(s_ready), 64'(i < DEPTH));
      tick();
    end
    s_valid = 1'b0;
    check("full_count", 64'(count), 64'(DEPTH));
    check("full_s_ready", 64'(s_ready), 64'(1'b0));
    m_ready = 1'b1;
    tick();
    check("s_ready_after_first_pop", 64'(s_ready), 64'(1'b1));
    for (int i = 0; i < DEPTH - 1; i++) tick();
    m_ready = 1'b0;
    check("drain_count", 64'(count), 64'(0));
    check("nar_seen_after_fill", 64'(nar_seen), 64'(nar_model));

    // streaming at occupancy 2 for 20 cycles
    s_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din = rnd_ent();
      tick();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din = rnd_ent();
      tick();
      check("stream_count", 64'(count), 64'(2));
    end
    s_valid = 1'b0;
    tick();
    tick();
    m_ready = 1'b0;
    check("stream_drain_count", 64'(count), 64'(0));
    check("nar_seen_after_stream", 64'(nar_seen), 64'(nar_model));

    // lane 2 NaR with scale 5
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("nar_seen_cleared", 64'(nar_seen), 64'(0));
    din = '0;
    din.scale[2*SW +: SW]       = SW'(5);
    din.flags[2*FL + PD_NAR]    = 1'b1;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
`ifdef POSIT_PD_CANON_EN
    check("nar_lane2_scale", 64'(m_scale[2*SW +: SW]), 64'(0));
    check("nar_lane2_sign", 64'(m_flags[2*FL + PD_SIGN]), 64'(1'b1));
`else
    check("nar_lane2_scale", 64'(m_scale[2*SW +: SW]), 64'(5));
    check("nar_lane2_sign", 64'(m_flags[2*FL + PD_SIGN]), 64'(1'b0));
`endif
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("nar_seen_lane2", 64'(nar_seen), 64'(4'b0100));

    // flush at count 3 with concurrent push and pop
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = rnd_ent();
      tick();
    end
    din     = rnd_ent();
    flush   = 1'b1;
    m_ready = 1'b1;
    tick();
    flush   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    check("flush_count", 64'(count), 64'(0));
    check("flush_m_valid", 64'(m_valid), 64'(1'b0));
    check("flush_nar_seen", 64'(nar_seen), 64'(0));
    check("flush_s_ready", 64'(s_ready), 64'(1'b1));
    tick();
    check("flush_push_dropped", 64'(m_valid), 64'(1'b0));

    // asynchronous reset mid-cycle at count 2
    s_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din = rnd_ent();
      tick();
    end
    s_valid = 1'b0;
    check("pre_reset_count", 64'(count), 64'(2));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_m_valid", 64'(m_valid), 64'(1'b0));
    check("async_rst_count", 64'(count), 64'(0));
    check("async_rst_s_ready", 64'(s_ready), 64'(1'b0));
    check("async_rst_nar_seen", 64'(nar_seen), 64'(0));
    sb_q.delete();
    nar_model = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_release_s_ready_low", 64'(s_ready), 64'(1'b0));
    @(posedge clk);
    #1 check("rst_release_s_ready_high", 64'(s_ready), 64'(1'b1));
    @(negedge clk);

    // post-reset sanity transfer
    din     = rnd_ent();
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("final_count", 64'(count), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
